debounce_unit: RTL and testbench

DEBOUNCE_UNIT -- requirements
Module: debounce_unit

---
 rtl/debounce_unit.sv | 151 +++++++++++++++
 tb/tb_debounce_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/debounce_unit.sv
// Multi-channel button debouncer: 2-flop sync, strobe-driven 4-state FSM per channel.
// Optional macro HOLD_REPEAT_EN adds auto-repeat press pulses while a button is held.
module debounce_unit #(
    parameter int NUM_BTN        = 4,
    parameter int STABLE_SAMPLES = 4,
    parameter int REPEAT_DELAY   = 64,
    parameter int REPEAT_RATE    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               debounce_clk,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_SAMPLES);

    if (NUM_BTN < 1 || NUM_BTN > 8 || STABLE_SAMPLES < 2 || STABLE_SAMPLES > 15 ||
        REPEAT_DELAY < 1 || REPEAT_DELAY > 255 || REPEAT_RATE < 1 || REPEAT_RATE > 255) begin : g_bad_cfg
        $error("debounce_unit: parameter out of range");
    end

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic               dclk_q;
    logic               armed;
    logic               tick;
    state_t             state [NUM_BTN];
    logic [3:0]         cnt   [NUM_BTN];

`ifdef HOLD_REPEAT_EN
    localparam logic [7:0] DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE  = 8'(REPEAT_RATE);
    logic [7:0]         hold [NUM_BTN];
    logic [NUM_BTN-1:0] repeating;
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

    // armed blocks a strobe that is already high when reset is released
    assign tick = debounce_clk & ~dclk_q & armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            dclk_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            sync1  <= btn_in;
            sync2  <= sync1;
            dclk_q <= debounce_clk;
            if (!debounce_clk)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
`ifdef HOLD_REPEAT_EN
                hold[i]  <= '0;
`endif
            end
`ifdef HOLD_REPEAT_EN
            repeating   <= '0;
`endif
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            if (tick) begin
                for (int unsigned i = 0; i < NUM_BTN; i++) begin
                    case (state[i])
                        RELEASED: begin
                            if (sync2[i]) begin
                                state[i] <= PRESS_PEND;
                                cnt[i]   <= 4'd1;
                            end
                        end
                        PRESS_PEND: begin
                            if (sync2[i]) begin
                                cnt[i] <= sat_inc(cnt[i]);
                                if (sat_inc(cnt[i]) == STABLE) begin
                                    state[i]     <= PRESSED;
                                    btn_level[i] <= 1'b1;
                                    btn_press[i] <= 1'b1;
`ifdef HOLD_REPEAT_EN
                                    hold[i]      <= '0;
                                    repeating[i] <= 1'b0;
`endif
                                end
                            end else begin
                                state[i] <= RELEASED;
                                cnt[i]   <= '0;
                            end
                        end
                        PRESSED: begin
                            if (!sync2[i]) begin
                                state[i] <= RELEASE_PEND;
                                cnt[i]   <= 4'd1;
                            end
`ifdef HOLD_REPEAT_EN
                            // hold restarts from zero after each repeat; first period DELAY, then RATE
                            else if (hold[i] + 8'd1 == (repeating[i] ? RATE : DELAY)) begin
                                btn_press[i] <= 1'b1;
                                repeating[i] <= 1'b1;
                                hold[i]      <= '0;
                            end else begin
                                hold[i] <= hold[i] + 8'd1;
                            end
`endif
                        end
                        RELEASE_PEND: begin
                            if (!sync2[i]) begin
                                cnt[i] <= sat_inc(cnt[i]);
                                if (sat_inc(cnt[i]) == STABLE) begin
                                    state[i]       <= RELEASED;
                                    btn_level[i]   <= 1'b0;
                                    btn_release[i] <= 1'b1;
                                end
                            end else begin
                                state[i] <= PRESSED;
                                cnt[i]   <= '0;
`ifdef HOLD_REPEAT_EN
                                hold[i]      <= '0;
                                repeating[i] <= 1'b0;
`endif
                            end
                        end
                        default: begin
                            state[i] <= RELEASED;
                            cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_debounce_unit.sv
// Scoreboard bench for debounce_unit: stimulus queues expected pulses, a monitor checks them.
module tb_debounce_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       debounce_clk;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    typedef struct {
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
        int         tick;
    } exp_t;

    exp_t sb[$];
    int   tick_no = 0;
    int   errors  = 0;
    int   checks  = 0;

    debounce_unit #(
        .NUM_BTN(4),
        .STABLE_SAMPLES(4),
        .REPEAT_DELAY(64),
        .REPEAT_RATE(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .debounce_clk(debounce_clk),
        .btn_in(btn_in),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick_no);
        end
    endtask

    task automatic push(input logic [3:0] p, input logic [3:0] r, input logic [3:0] l, input int t);
        exp_t e;
        e.press = p;
        e.rel   = r;
        e.level = l;
        e.tick  = t;
        sb.push_back(e);
    endtask

    task automatic do_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1 debounce_clk = 1'b1;
            tick_no++;
            @(posedge clk);
            #1 debounce_clk = 1'b0;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic set_btn(input logic [3:0] v);
        #1 btn_in = v;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_outputs(input string name, input logic [3:0] lvl);
        @(negedge clk);
        check({name, "_level"}, int'(btn_level), int'(lvl));
        check({name, "_pulses"}, int'({btn_press, btn_release}), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && ((btn_press | btn_release) != 4'b0)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", int'({btn_press, btn_release}), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("press_vec", int'(btn_press), int'(e.press));
                check("release_vec", int'(btn_release), int'(e.rel));
                check("level_at_pulse", int'(btn_level), int'(e.level));
                check("pulse_tick", tick_no, e.tick);
            end
        end
    end

    initial begin
        rst          = 1'b1;
        debounce_clk = 1'b0;
        btn_in       = 4'b0;
        repeat (3) @(posedge clk);
        check_outputs("reset", 4'b0000);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // idle: no pulses, level stays low
        do_ticks(20);
        check_outputs("idle", 4'b0000);

        // single press / release on channel 0
        set_btn(4'b0001);
        push(4'b0001, 4'b0000, 4'b0001, tick_no + 4);
        do_ticks(6);
        check_outputs("held0", 4'b0001);
        set_btn(4'b0000);
        push(4'b0000, 4'b0001, 4'b0000, tick_no + 4);
        do_ticks(6);
        check_outputs("rel0", 4'b0000);

        // glitch of 3 ticks on channel 1 is rejected
        set_btn(4'b0010);
        do_ticks(3);
        set_btn(4'b0000);
        do_ticks(6);
        check_outputs("glitch1", 4'b0000);

        // channels 2 and 3 together
        set_btn(4'b1100);
        push(4'b1100, 4'b0000, 4'b1100, tick_no + 4);
        do_ticks(6);
        check_outputs("held23", 4'b1100);
        set_btn(4'b0000);
        push(4'b0000, 4'b1100, 4'b0000, tick_no + 4);
        do_ticks(6);
        check_outputs("rel23", 4'b0000);

        // reset mid-debounce, released while strobe is already high
        set_btn(4'b0001);
        do_ticks(2);
        #1 rst = 1'b1;
        debounce_clk = 1'b1;
        check_outputs("mid_reset", 4'b0000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 debounce_clk = 1'b0;
        repeat (2) @(posedge clk);
        push(4'b0001, 4'b0000, 4'b0001, tick_no + 4);
        do_ticks(6);
        check_outputs("reheld0", 4'b0001);
        set_btn(4'b0000);
        push(4'b0000, 4'b0001, 4'b0000, tick_no + 4);
        do_ticks(6);

        // long hold on channel 0
        set_btn(4'b0001);
        push(4'b0001, 4'b0000, 4'b0001, tick_no + 4);
`ifdef HOLD_REPEAT_EN
        push(4'b0001, 4'b0000, 4'b0001, tick_no + 4 + 64);
        push(4'b0001, 4'b0000, 4'b0001, tick_no + 4 + 80);
        push(4'b0001, 4'b0000, 4'b0001, tick_no + 4 + 96);
`endif
        do_ticks(104);
        check_outputs("long_hold", 4'b0001);
        set_btn(4'b0000);
        push(4'b0000, 4'b0001, 4'b0000, tick_no + 4);
        do_ticks(6);
        check_outputs("final", 4'b0000);

        check("scoreboard_left", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
